operand_pair_buffer: RTL

OPERAND_PAIR_BUFFER -- requirements
Module: operand_pair_buffer

---
 rtl/operand_pkg.sv | 13 +
 rtl/stb_fifo.sv | 52 +++++
 rtl/operand_pair_buffer.sv | 75 +++++++
 3 files changed

// File: rtl/operand_pkg.sv
// Shared defaults and slot-state encoding for the operand pairing path.
package operand_pkg;

  localparam int OPB_WIDTH  = 32;
  localparam int OPB_DEPTH  = 4;
  localparam int PAIR_CNT_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/stb_fifo.sv
// Strobe/ack FIFO for one operand stream; the storage array is never cleared,
// only the pointers and the level are.
module stb_fifo
  import operand_pkg::*;
#(
  parameter int WIDTH = OPB_WIDTH,
  parameter int DEPTH = OPB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   push_stb,
  output logic                   push_ack,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop_ok;

  // Ack looks only at the current level, so a full FIFO refuses even if it pops this edge.
  assign push_ack = rst && (level != LVL_FULL);
  assign push     = push_stb && push_ack;
  assign pop_ok   = pop && (level != '0);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/operand_pair_buffer.sv
// Buffers the A and B operand streams and presents them to the multiplier as
// in-order pairs through a single registered output slot.
module operand_pair_buffer
  import operand_pkg::*;
#(
  parameter int WIDTH = OPB_WIDTH,
  parameter int DEPTH = OPB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       input_a,
  input  logic                   input_a_stb,
  output logic                   input_a_ack,
  input  logic [WIDTH-1:0]       input_b,
  input  logic                   input_b_stb,
  output logic                   input_b_ack,
  output logic [WIDTH-1:0]       output_a,
  output logic [WIDTH-1:0]       output_b,
  output logic                   output_ab_stb,
  input  logic                   output_ab_ack,
  output logic [PAIR_CNT_W-1:0]  pair_count,
  output logic [$clog2(DEPTH):0] level_a,
  output logic [$clog2(DEPTH):0] level_b
);

  logic [WIDTH-1:0] head_a, head_b;
  logic             pair_avail, pop_pair;
  slot_state_t      slot;

  stb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push_data (input_a),
    .push_stb  (input_a_stb),
    .push_ack  (input_a_ack),
    .pop       (pop_pair),
    .head      (head_a),
    .level     (level_a)
  );

  stb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push_data (input_b),
    .push_stb  (input_b_stb),
    .push_ack  (input_b_ack),
    .pop       (pop_pair),
    .head      (head_b),
    .level     (level_b)
  );

  // Both heads leave together, which keeps the k-th A aligned with the k-th B.
  assign pair_avail    = (level_a != '0) && (level_b != '0);
  assign pop_pair      = pair_avail && ((slot == SLOT_EMPTY) || output_ab_ack);
  assign output_ab_stb = (slot == SLOT_FULL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot       <= SLOT_EMPTY;
      output_a   <= '0;
      output_b   <= '0;
      pair_count <= '0;
    end else begin
      if ((slot == SLOT_FULL) && output_ab_ack) pair_count <= pair_count + 1'b1;
      if (pop_pair) begin
        slot     <= SLOT_FULL;
        output_a <= head_a;
        output_b <= head_b;
      end else if (output_ab_ack) begin
        slot     <= SLOT_EMPTY;
      end
    end
  end

endmodule
